// File: rtl/battle_turn_ctrl.sv
// Battle turn sequencer: HP init, alternating saturating attacks with view pauses, victory/loss/draw.
// Optional SPEED_ORDER_EN: faster trainer (AI only when strictly faster) attacks first each turn.
module battle_turn_ctrl #(
   parameter int HP_W      = 8,
   parameter int DMG_W     = 8,
   parameter int TURN_W    = 8,
   parameter int MAX_TURNS = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              go,
   input  logic [HP_W-1:0]   p_hp_init,
   input  logic [HP_W-1:0]   ai_hp_init,
   input  logic [DMG_W-1:0]  p_dmg,
   input  logic [DMG_W-1:0]  ai_dmg,
   input  logic [7:0]        p_spd,
   input  logic [7:0]        ai_spd,
   output logic [HP_W-1:0]   p_hp,
   output logic [HP_W-1:0]   ai_hp,
   output logic [TURN_W-1:0] turn_count,
   output logic [3:0]        state_code,
   output logic              active_trainer,
   output logic              target,
   output logic              apply_p_damage,
   output logic              apply_ai_damage,
   output logic              victory,
   output logic              loss,
   output logic              draw
);

   localparam int CMP_W = (HP_W > DMG_W) ? HP_W : DMG_W;
   localparam logic [TURN_W-1:0] MAX_T = TURN_W'(MAX_TURNS);

   typedef enum logic [3:0] {
      S_INIT         = 4'd0,
      S_LOAD_PM      = 4'd1,
      S_UPDATE_AI_HP = 4'd2,
      S_VIEW_AI_HP   = 4'd3,
      S_UPDATE_P_HP  = 4'd4,
      S_VIEW_P_HP    = 4'd5,
      S_TURN_END     = 4'd6,
      S_VICTORY      = 4'd7,
      S_LOSS         = 4'd8,
      S_DRAW         = 4'd9
   } state_t;

   function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp, input logic [DMG_W-1:0] dmg);
      logic [CMP_W-1:0] hp_x;
      logic [CMP_W-1:0] dmg_x;
      logic [CMP_W-1:0] diff;
      hp_x  = CMP_W'(hp);
      dmg_x = CMP_W'(dmg);
      diff  = hp_x - dmg_x;
      if (dmg_x >= hp_x) sat_sub = '0;
      else               sat_sub = diff[HP_W-1:0];
   endfunction

   state_t             state_r, state_s;
   logic               go_q_r;
   logic               go_pulse_s;
   logic [HP_W-1:0]    p_hp_r, p_hp_s, ai_hp_r, ai_hp_s;
   logic [TURN_W-1:0]  turn_r, turn_s, turn_inc_s;
   logic [DMG_W-1:0]   p_dmg_r, p_dmg_s, ai_dmg_r, ai_dmg_s;
   logic               second_r, second_s;
   logic               first_ai_s;
   logic               apply_p_r, apply_ai_r, active_r, target_r;
   logic               victory_r, loss_r, draw_r;

   assign go_pulse_s = go & ~go_q_r;
   assign turn_inc_s = turn_r + TURN_W'(1);

`ifdef SPEED_ORDER_EN
   assign first_ai_s = (ai_spd > p_spd);
`else
   logic spd_unused_s;
   assign spd_unused_s = ^{p_spd, ai_spd};
   assign first_ai_s   = 1'b0;
`endif

   // Next-state, HP saturation, damage latching and turn counting
   always_comb begin
      state_s  = state_r;
      p_hp_s   = p_hp_r;
      ai_hp_s  = ai_hp_r;
      turn_s   = turn_r;
      p_dmg_s  = p_dmg_r;
      ai_dmg_s = ai_dmg_r;
      second_s = second_r;
      case (state_r)
         S_INIT: begin
            if (go_pulse_s) begin
               p_hp_s  = p_hp_init;
               ai_hp_s = ai_hp_init;
               turn_s  = '0;
               state_s = S_LOAD_PM;
            end else begin
               state_s = S_INIT;
            end
         end
         S_LOAD_PM: begin
            if (go_pulse_s) begin
               p_dmg_s  = p_dmg;
               ai_dmg_s = ai_dmg;
               second_s = 1'b0;
               state_s  = first_ai_s ? S_UPDATE_P_HP : S_UPDATE_AI_HP;
            end else begin
               state_s = S_LOAD_PM;
            end
         end
         S_UPDATE_AI_HP: begin
            ai_hp_s = sat_sub(ai_hp_r, p_dmg_r);
            state_s = S_VIEW_AI_HP;
         end
         S_UPDATE_P_HP: begin
            p_hp_s  = sat_sub(p_hp_r, ai_dmg_r);
            state_s = S_VIEW_P_HP;
         end
         S_VIEW_AI_HP: begin
            if (!go_pulse_s)          state_s = S_VIEW_AI_HP;
            else if (ai_hp_r == '0)   state_s = S_VICTORY;
            else if (second_r)        state_s = S_TURN_END;
            else begin
               second_s = 1'b1;
               state_s  = S_UPDATE_P_HP;
            end
         end
         S_VIEW_P_HP: begin
            if (!go_pulse_s)          state_s = S_VIEW_P_HP;
            else if (p_hp_r == '0)    state_s = S_LOSS;
            else if (second_r)        state_s = S_TURN_END;
            else begin
               second_s = 1'b1;
               state_s  = S_UPDATE_AI_HP;
            end
         end
         S_TURN_END: begin
            turn_s = turn_inc_s;
            if ((MAX_TURNS != 0) && (turn_inc_s == MAX_T)) state_s = S_DRAW;
            else                                           state_s = S_LOAD_PM;
         end
         S_VICTORY, S_LOSS, S_DRAW: begin
            if (go_pulse_s) state_s = S_INIT;
            else            state_s = state_r;
         end
         default: state_s = S_INIT;
      endcase
   end

   // State, datapath registers and outputs decoded one cycle early so they align with the state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= S_INIT;
         go_q_r     <= 1'b0;
         p_hp_r     <= '0;
         ai_hp_r    <= '0;
         turn_r     <= '0;
         p_dmg_r    <= '0;
         ai_dmg_r   <= '0;
         second_r   <= 1'b0;
         apply_p_r  <= 1'b0;
         apply_ai_r <= 1'b0;
         active_r   <= 1'b0;
         target_r   <= 1'b0;
         victory_r  <= 1'b0;
         loss_r     <= 1'b0;
         draw_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         go_q_r     <= go;
         p_hp_r     <= p_hp_s;
         ai_hp_r    <= ai_hp_s;
         turn_r     <= turn_s;
         p_dmg_r    <= p_dmg_s;
         ai_dmg_r   <= ai_dmg_s;
         second_r   <= second_s;
         apply_p_r  <= (state_s == S_UPDATE_P_HP);
         apply_ai_r <= (state_s == S_UPDATE_AI_HP);
         active_r   <= (state_s == S_UPDATE_P_HP);
         target_r   <= (state_s == S_UPDATE_AI_HP);
         victory_r  <= (state_s == S_VICTORY);
         loss_r     <= (state_s == S_LOSS);
         draw_r     <= (state_s == S_DRAW);
      end
   end

   assign p_hp            = p_hp_r;
   assign ai_hp           = ai_hp_r;
   assign turn_count      = turn_r;
   assign state_code      = state_r;
   assign active_trainer  = active_r;
   assign target          = target_r;
   assign apply_p_damage  = apply_p_r;
   assign apply_ai_damage = apply_ai_r;
   assign victory         = victory_r;
   assign loss            = loss_r;
   assign draw            = draw_r;

endmodule

// File: doc/battle_turn_ctrl.md
# battle_turn_ctrl

Parametrised turn controller for the Pokémon battle system. It sequences a full battle: HP initialisation, move selection, player and AI attacks with view/acknowledge pauses, and victory, loss or draw detection. It owns both HP registers and applies saturating damage. It sits between the move-select/LFSR front end and the HP display/VGA datapath.

## Interface
Parameters:
- HP_W, 8: width of HP registers and init inputs.
- DMG_W, 8: width of damage inputs.
- TURN_W, 8: width of turn counter.
- MAX_TURNS, 0: turn limit before draw; 0 = unlimited.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- go  in  1  user advance button; level input, internally edge-detected.
- p_hp_init  in  HP_W  player starting HP.
- ai_hp_init  in  HP_W  AI starting HP.
- p_dmg  in  DMG_W  damage of the player's selected move.
- ai_dmg  in  DMG_W  damage of the AI's selected move.
- p_spd, ai_spd  in  8  speed stats (used only with SPEED_ORDER_EN).
- p_hp, ai_hp  out  HP_W  current HP registers.
- turn_count  out  TURN_W  completed turns.
- state_code  out  4  current state encoding.
- active_trainer, target  out  1  0 = player, 1 = AI.
- apply_p_damage, apply_ai_damage  out  1  one-cycle strobes.
- victory, loss, draw  out  1  terminal flags.

## Operation
- go_pulse = go & ~go_q; go_q resets to 0. A go that is already high at reset release counts as one edge. Holding go advances exactly one step.
- State codes:
  - S_INIT=0
  - S_LOAD_PM=1
  - S_UPDATE_AI_HP=2
  - S_VIEW_AI_HP=3
  - S_UPDATE_P_HP=4
  - S_VIEW_P_HP=5
  - S_TURN_END=6
  - S_VICTORY=7
  - S_LOSS=8
  - S_DRAW=9
  - Unused codes go to S_INIT.
- S_INIT: on go_pulse, load p_hp/ai_hp from the init inputs, clear turn_count, go to S_LOAD_PM.
- S_LOAD_PM: on go_pulse, latch p_dmg/ai_dmg into internal registers, clear the second-attack flag, go to the first attacker's UPDATE state. The player attacks first by default.
- S_UPDATE_AI_HP, one cycle:
  - ai_hp ← (p_dmg_r ≥ ai_hp) ? 0 : ai_hp − p_dmg_r.
  - Outputs: apply_ai_damage=1, active_trainer=0, target=1.
  - Go to S_VIEW_AI_HP.
- S_UPDATE_P_HP, mirror of S_UPDATE_AI_HP:
  - p_hp is saturated with ai_dmg_r.
  - Outputs: apply_p_damage=1, active_trainer=1, target=0.
  - Go to S_VIEW_P_HP.
- VIEW states hold until go_pulse, then:
  - Defender HP == 0 → S_VICTORY (from S_VIEW_AI_HP) or S_LOSS (from S_VIEW_P_HP).
  - Else, if the second attack is done → S_TURN_END.
  - Else, set the second-attack flag and go to the other UPDATE state.
- S_TURN_END, one cycle: turn_count += 1 (wraps at 2^TURN_W).
  - If MAX_TURNS ≠ 0 and turn_count+1 == MAX_TURNS → S_DRAW.
  - Else → S_LOAD_PM.
- Terminal states hold their flag high. go_pulse → S_INIT; HP and turn_count are retained until reloaded.
- Compares are done at max(HP_W, DMG_W) with zero extension; no signed arithmetic.

## Timing
- Reset (synchronous, any state, mid-attack included):
  - state S_INIT; p_hp=ai_hp=0; turn_count=0; latched damage 0.
  - All strobes and flags 0; active_trainer=target=0; go_q=0.
- Outputs are a Moore decode of the registered state; strobes last exactly one cycle per UPDATE entry.
- HP updates on the clock edge that leaves the UPDATE state, so the new HP is visible for all of the VIEW state.
- Latency from a go_pulse in a VIEW state to the next UPDATE strobe is 1 cycle.
- Damage and speed inputs are sampled only on the S_LOAD_PM go_pulse; changes at other times are ignored.

## Configuration
- SPEED_ORDER_EN defined: speeds are sampled at S_LOAD_PM.
  - If ai_spd > p_spd, the AI attacks first (S_UPDATE_P_HP first).
  - On a tie, or if ai_spd < p_spd, the player attacks first.
- SPEED_ORDER_EN undefined: the player always attacks first; p_spd/ai_spd are unused.

## Test plan
- Victory path: init 20/15, p_dmg 6, ai_dmg 4, repeated go → AI/player HP 9/16, then 3/12, then ai_hp 0. S_VICTORY follows the third AI view with no third player update; turn_count=2; victory=1.
- Saturation and loss: init player 3, AI 50, p_dmg 1, ai_dmg 10 → ai_hp 49, p_hp 0 (not wrapped), S_LOSS, loss=1.
- Draw: MAX_TURNS=2, init 100/100, damage 1/1 → S_DRAW after the second S_TURN_END; turn_count=2, both HP 98.
- Go handshake: go held high for 10 cycles in S_LOAD_PM → exactly one state advance; each strobe is high for exactly 1 cycle.
- Reset mid-battle: assert reset_n=0 in S_VIEW_P_HP → next cycle state_code=0 and all outputs 0. A go then reloads the init HP.
- SPEED_ORDER_EN: ai_spd=9, p_spd=5 → apply_p_damage strobes before apply_ai_damage. With equal speeds, player first.
